// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one UART transmitter.
// Define UART_ARB_TIMEOUT_EN to add a watchdog on the transmitter's busy handshake.
module uart_tx_arbiter #(
    parameter int DATA_W         = 7,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] data_in,
    output logic [3:0]          ack,
    output logic                tx_start,
    output logic [DATA_W-1:0]   tx_data,
    input  logic                tx_busy,
    output logic [1:0]          grant_id,
    output logic                active,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [1:0]          grant_id_q, grant_id_d;
    logic [1:0]          last_q, last_d;

    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic [1:0]          probe_idx;
    logic [DATA_W-1:0]   pick_data;
    logic                waiting;
    logic                timeout_hit;

    assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

    // Walk from last+4 down to last+1 so the nearest requester after last wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_q;
        probe_idx  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            probe_idx = last_q + 2'(k);
            if (req[probe_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = probe_idx;
            end
        end
    end

    always_comb begin
        pick_data = data_in[DATA_W-1:0];
        for (int i = 0; i < 4; i++) begin
            if (pick_idx == 2'(i)) begin
                pick_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // Counter restarts as the FSM leaves START, i.e. on WAIT_BUSY entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == START) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timeout_err_d = timeout_err_q;
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    wire unused_timeout_cfg = |TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid && !tx_busy) begin
                    state_d    = START;
                    tx_data_d  = pick_data;
                    grant_id_d = pick_idx;
                end
            end
            START: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                    last_d  = grant_id_q;
                end else if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (timeout_hit || !tx_busy) begin
                    state_d = IDLE;
                    last_d  = grant_id_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last resets to 3 so requester 0 is first in line after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            grant_id_q <= 2'd0;
            last_q     <= 2'd3;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
        end
    end

    assign tx_start = (state_q == START);
    assign ack      = tx_start ? (4'b0001 << grant_id_q) : 4'b0000;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed tests push expected grants,
// a negedge monitor pops and compares them whenever tx_start is seen.
module tb_uart_tx_arbiter;

    localparam int DATA_W = 7;
    localparam int TO_CYC = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] data_in;
    logic [3:0]          ack;
    logic                tx_start;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_busy;
    logic [1:0]          grant_id;
    logic                active;
    logic                timeout_err;

    logic model_busy   = 1'b0;
    logic foreign_busy = 1'b0;
    logic model_en     = 1'b1;

    assign tx_busy = model_busy | foreign_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [1:0]        gid;
        logic [DATA_W-1:0] data;
        logic [3:0]        ackv;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   compared    = 0;
    int   mismatched  = 0;
    int   start_count = 0;
    int   ack_count[4];
    logic              tracking = 1'b0;
    logic [DATA_W-1:0] held_data;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [1:0] g, input logic [DATA_W-1:0] d, input logic [3:0] a);
        exp_t e;
        e.gid  = g;
        e.data = d;
        e.ackv = a;
        sb_q.push_back(e);
    endtask

    task automatic setSlot(input int i, input logic [DATA_W-1:0] v);
        data_in[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        @(posedge clk);
        #1 req = r;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ack"}, ack, 0);
        checkOutput({tag, "_tx_start"}, tx_start, 0);
        checkOutput({tag, "_tx_data"}, tx_data, 0);
        checkOutput({tag, "_grant_id"}, grant_id, 0);
        checkOutput({tag, "_active"}, active, 0);
        checkOutput({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic waitBusyLow(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (tx_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, tx_busy, 0);
    endtask

    task automatic applyReset();
        waitBusyLow("pre_reset_busy_low", 40);
        req          = 4'b0000;
        foreign_busy = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) ack_count[i] = 0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (active && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, active, 0);
    endtask

    task automatic waitStart(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (!tx_start && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, tx_start, 1);
    endtask

    // Transmitter model: busy rises one cycle after the start strobe, lasts 10 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && model_en) begin
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every start strobe and watches ack/tx_data elsewhere.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                start_count++;
                for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) ack_count[i]++;
                if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_start: actual grant_id=%0d tx_data=0x%0h required=no pending grant",
                             grant_id, tx_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("sb_grant_id", grant_id, mon_e.gid);
                    checkOutput("sb_tx_data", tx_data, mon_e.data);
                    checkOutput("sb_ack", ack, mon_e.ackv);
                end
                tracking  = 1'b1;
                held_data = tx_data;
            end else begin
                checkOutput("ack_outside_start", ack, 0);
                if (active !== 1'b1) begin
                    tracking = 1'b0;
                end else if (tracking) begin
                    checkOutput("tx_data_stable", tx_data, held_data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: actual=still running required=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $finish;
    end

    initial begin
        int base;
        int n;
        rst     = 1'b0;
        req     = 4'b0000;
        data_in = '0;
        #1 rst = 1'b1;

        // Single requester 2, then return to idle.
        applyReset();
        @(negedge clk);
        checkResetValues("reset");
        setSlot(2, 7'h41);
        pushExp(2'd2, 7'h41, 4'b0100);
        applyStimulus(4'b0100);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lat_tx_start", tx_start, 1);
        checkOutput("lat_active", active, 1);
        req = 4'b0000;
        waitIdle("single_return_idle", 40);
        checkOutput("single_grant_id_kept", grant_id, 2);

        // All four held: round-robin 0,1,2,3,0.
        applyReset();
        for (int i = 0; i < 4; i++) setSlot(i, 7'h10 + 7'(i));
        pushExp(2'd0, 7'h10, 4'b0001);
        pushExp(2'd1, 7'h11, 4'b0010);
        pushExp(2'd2, 7'h12, 4'b0100);
        pushExp(2'd3, 7'h13, 4'b1000);
        pushExp(2'd0, 7'h10, 4'b0001);
        base = start_count;
        applyStimulus(4'b1111);
        n = 0;
        while (start_count - base < 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        req = 4'b0000;
        checkOutput("rr_five_starts", start_count - base, 5);
        waitIdle("rr_return_idle", 40);
        checkOutput("rr_ack0_count", ack_count[0], 2);
        checkOutput("rr_ack1_count", ack_count[1], 1);
        checkOutput("rr_ack2_count", ack_count[2], 1);
        checkOutput("rr_ack3_count", ack_count[3], 1);

        // Foreign busy in IDLE blocks the grant.
        applyReset();
        setSlot(0, 7'h5A);
        pushExp(2'd0, 7'h5A, 4'b0001);
        foreign_busy = 1'b1;
        applyStimulus(4'b0001);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("busy_blocks_start", tx_start, 0);
        end
        @(posedge clk);
        #1 foreign_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_release_start", tx_start, 1);
        req = 4'b0000;
        waitIdle("busy_return_idle", 40);

        // Request dropped right after the latch edge still completes.
        applyReset();
        setSlot(1, 7'h55);
        pushExp(2'd1, 7'h55, 4'b0010);
        applyStimulus(4'b0010);
        @(posedge clk);
        #1 req = 4'b0000;
        setSlot(1, 7'h2A);
        @(negedge clk);
        checkOutput("drop_tx_start", tx_start, 1);
        waitIdle("drop_return_idle", 40);
        repeat (5) @(negedge clk);
        checkOutput("drop_ack1_once", ack_count[1], 1);

        // Reset during WAIT_DONE, then requester 0 is granted.
        applyReset();
        setSlot(2, 7'h33);
        pushExp(2'd2, 7'h33, 4'b0100);
        applyStimulus(4'b0100);
        waitStart("rst_mid_start", 10);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        checkOutput("rst_mid_in_wait_done", tx_busy & active, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkResetValues("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        waitBusyLow("rst_mid_busy_low", 40);
        setSlot(0, 7'h11);
        pushExp(2'd0, 7'h11, 4'b0001);
        applyStimulus(4'b0001);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_regrant", tx_start, 1);
        req = 4'b0000;
        waitIdle("rst_mid_return_idle", 40);

        // Transmitter never responds: watchdog or indefinite wait.
        applyReset();
        model_en = 1'b0;
        setSlot(0, 7'h7E);
        pushExp(2'd0, 7'h7E, 4'b0001);
        applyStimulus(4'b0001);
        @(posedge clk);
        @(negedge clk);
        checkOutput("to_tx_start", tx_start, 1);
        req = 4'b0000;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput("to_still_waiting", active, 1);
        @(posedge clk);
        @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
        checkOutput("to_back_idle", active, 0);
        checkOutput("to_err_set", timeout_err, 1);
        repeat (5) @(negedge clk);
        checkOutput("to_err_sticky", timeout_err, 1);
`else
        checkOutput("to_no_watchdog_active", active, 1);
        checkOutput("to_no_watchdog_err", timeout_err, 0);
        repeat (20) @(negedge clk);
        checkOutput("to_still_active", active, 1);
        checkOutput("to_err_zero", timeout_err, 0);
`endif
        model_en = 1'b1;
        applyReset();
        @(negedge clk);
        checkOutput("to_err_cleared", timeout_err, 0);
        checkOutput("to_reset_idle", active, 0);

        checkOutput("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
